load_align_unit: RTL and testbench
==================================

// Module: load_align_unit
// PURPOSE
// Writeback-side load engine, directly upstream of the truncator. Takes one load request per
// transaction, fetches DATA_WIDTH-wide aligned beats over a valid/ready memory port, splits
// misaligned loads into two beats, and right-justifies the addressed bytes. Emits the raw
// aligned word plus TruncSrc to the truncator, which performs sign/zero extension.
// PARAMETERS
// DATA_WIDTH  32  memory beat / register width; 32 or 64 only (equals `BIT_COUNT)
// ADDR_WIDTH  32  byte address width
// PORTS
// clk            in   1           clock; all state updates on rising edge
// reset_n        in   1           synchronous reset, active-low
// ReqValid       in   1           load request valid
// ReqReady       out  1           unit can accept a request (high only in IDLE)
// ReqAddr        in   ADDR_WIDTH  byte address of load
// ReqTruncSrc    in   truncSrc    load kind; selects access size
// ReqRd          in   5           destination register, passed through
// Flush          in   1           abandon the in-flight load
// MemReqValid    out  1           memory read request valid
// MemReqReady    in   1           memory accepts request
// MemAddr        out  ADDR_WIDTH  beat-aligned read address (low log2(DATA_WIDTH/8) bits zero)
// MemRespValid   in   1           read data valid; one response per accepted request, in order
// MemRespData    in   DATA_WIDTH  read beat
// LoadValid      out  1           aligned result valid
// LoadReady      in   1           downstream consumes result
// LoadData       out  DATA_WIDTH  addressed bytes right-justified, upper bytes undefined-zeroed
// LoadTruncSrc   out  truncSrc    registered ReqTruncSrc (drives truncator TruncSrc)
// LoadRd         out  5           registered ReqRd
// LoadSplit      out  1           result required two beats (perf/debug)
// BEHAVIOUR
// - Reset (reset_n=0 at edge): state IDLE; ReqReady=1 after reset; MemReqValid, LoadValid,
//   LoadSplit=0; MemAddr, LoadData, LoadRd=0; LoadTruncSrc=NO_TRUNC. Reset mid-operation
//   aborts immediately; an outstanding memory response is the memory's responsibility.
// - Size: BYTE/BYTE_UNSIGNED=1, HALF_WORD/_UNSIGNED=2, WORD/WORD_UNSIGNED=4, NO_TRUNC=DATA_WIDTH/8.
//   B=DATA_WIDTH/8; off=ReqAddr mod B; split = (off+size > B).
// - FSM: IDLE -> REQ0 on ReqValid&ReqReady (addr/size/TruncSrc/Rd registered).
//   REQ0: MemReqValid=1, MemAddr=ReqAddr & ~(B-1); held stable until MemReqReady -> WAIT0.
//   WAIT0: on MemRespValid capture beat0 -> REQ1 if split, else DONE.
//   REQ1: MemAddr=beat0 addr + B (wraps mod 2^ADDR_WIDTH); on MemReqReady -> WAIT1.
//   WAIT1: on MemRespValid capture beat1 -> DONE.
//   DONE: LoadValid=1, outputs stable until LoadReady -> IDLE.
// - LoadData = ({beat1,beat0} >> 8*off)[DATA_WIDTH-1:0]; bytes above size forced 0; beat1=0 if !split.
// - Response in same cycle as its request handshake is not possible; responses seen in IDLE,
//   REQ0, REQ1 or DONE are ignored.
// - Min latency (aligned, zero-wait memory): accept T, MemReq T+1, resp T+2, LoadValid T+3.
//   Split adds 2 cycles. No request accepted while LoadValid held (single transaction).
// - Flush: IDLE/DONE/REQx (request not yet accepted) -> IDLE next cycle, no result.
//   WAITx -> DRAIN: wait for the owed MemRespValid, discard, -> IDLE. Flush in DRAIN: no effect.
//   Flush coincident with MemRespValid in WAITx: response discarded, -> IDLE.
//   Flush has priority over LoadReady, MemReqReady and ReqValid in the same cycle.
// - ReqReady is combinational from state only (=IDLE); no dependence on ReqValid.
// TESTING
// - DATA_WIDTH=32, load WORD @0x100, mem returns 0xDEADBEEF one cycle later -> single
//   MemAddr=0x100, LoadData=0xDEADBEEF, LoadValid at accept+3, LoadSplit=0.
// - BYTE_UNSIGNED @0x103, beat 0x80FFEE11 -> MemAddr=0x100, LoadData=0x00000080.
// - HALF_WORD @0x103, beats 0xAABBCCDD then 0x11223344 -> MemAddr 0x100 then 0x104,
//   LoadData=0x000044AA, LoadSplit=1, LoadValid at accept+5.
// - WORD @0xFFFFFFFE -> second MemAddr wraps to 0x00000000; LoadData from both beats.
// - Flush in WAIT0 with response 3 cycles later -> no LoadValid, ReqReady returns only after
//   response absorbed; following load returns its own data.
// - LoadReady low 4 cycles in DONE, MemReqReady low 3 cycles in REQ0 -> all outputs stable;
//   reset_n low in WAIT1 -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/load_align_unit.sv
// Purpose: writeback load engine; fetches one or two aligned beats and right-justifies the addressed bytes.
// Latency: accept T, MemReq T+1, resp T+2, LoadValid T+3 (aligned); a split load adds two cycles.
// Backpressure: ReqReady only in IDLE; REQx holds address until MemReqReady; DONE holds result until LoadReady.

package load_align_pkg;
  // Load kind encoding shared with the truncator.
  localparam logic [2:0] NO_TRUNC           = 3'd0;
  localparam logic [2:0] BYTE               = 3'd1;
  localparam logic [2:0] BYTE_UNSIGNED      = 3'd2;
  localparam logic [2:0] HALF_WORD          = 3'd3;
  localparam logic [2:0] HALF_WORD_UNSIGNED = 3'd4;
  localparam logic [2:0] WORD               = 3'd5;
  localparam logic [2:0] WORD_UNSIGNED      = 3'd6;
endpackage

module load_align_unit
  import load_align_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic [ADDR_WIDTH-1:0] ReqAddr,
  input  logic [2:0]            ReqTruncSrc,
  input  logic [4:0]            ReqRd,
  input  logic                  Flush,
  output logic                  MemReqValid,
  input  logic                  MemReqReady,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  input  logic                  MemRespValid,
  input  logic [DATA_WIDTH-1:0] MemRespData,
  output logic                  LoadValid,
  input  logic                  LoadReady,
  output logic [DATA_WIDTH-1:0] LoadData,
  output logic [2:0]            LoadTruncSrc,
  output logic [4:0]            LoadRd,
  output logic                  LoadSplit
);

  localparam int B    = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(B);
  localparam int SZW  = OFFW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_DONE, S_DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [OFFW-1:0]       off_q, off_d;
  logic [SZW-1:0]        size_q, size_d;
  logic [2:0]            trunc_q, trunc_d;
  logic [4:0]            rd_q, rd_d;
  logic                  split_q, split_d;
  logic [DATA_WIDTH-1:0] beat0_q, beat0_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;

  // Access size in bytes; NO_TRUNC means a full beat.
  function automatic logic [SZW-1:0] size_of(input logic [2:0] t);
    case (t)
      BYTE, BYTE_UNSIGNED:           size_of = SZW'(1);
      HALF_WORD, HALF_WORD_UNSIGNED: size_of = SZW'(2);
      WORD, WORD_UNSIGNED:           size_of = SZW'(4);
      default:                       size_of = SZW'(B);
    endcase
  endfunction

  // Shift the two-beat window down by the byte offset and clear bytes beyond the access size.
  function automatic logic [DATA_WIDTH-1:0] align(input logic [DATA_WIDTH-1:0] hi,
                                                  input logic [DATA_WIDTH-1:0] lo,
                                                  input logic [OFFW-1:0]       off,
                                                  input logic [SZW-1:0]        sz);
    logic [2*DATA_WIDTH-1:0] cat;
    logic [DATA_WIDTH-1:0]   res;
    cat = {hi, lo} >> {off, 3'b000};
    res = cat[DATA_WIDTH-1:0];
    for (int i = 0; i < B; i++) begin
      if (SZW'(i) >= sz) res[8*i +: 8] = 8'h00;
    end
    return res;
  endfunction

  logic [OFFW-1:0] req_off;
  logic [SZW-1:0]  req_size;
  assign req_off  = ReqAddr[OFFW-1:0];
  assign req_size = size_of(ReqTruncSrc);

  assign ReqReady     = (state_q == S_IDLE);
  assign MemReqValid  = (state_q == S_REQ0) || (state_q == S_REQ1);
  assign MemAddr      = mem_addr_q;
  assign LoadValid    = (state_q == S_DONE);
  assign LoadData     = load_data_q;
  assign LoadTruncSrc = trunc_q;
  assign LoadRd       = rd_q;
  assign LoadSplit    = split_q;

  // Next-state and datapath capture; Flush outranks every other event.
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    size_d      = size_q;
    trunc_d     = trunc_q;
    rd_d        = rd_q;
    split_d     = split_q;
    beat0_d     = beat0_q;
    mem_addr_d  = mem_addr_q;
    load_data_d = load_data_q;
    case (state_q)
      S_IDLE: begin
        if (!Flush && ReqValid) begin
          off_d      = req_off;
          size_d     = req_size;
          trunc_d    = ReqTruncSrc;
          rd_d       = ReqRd;
          split_d    = (SZW'(req_off) + req_size) > SZW'(B);
          mem_addr_d = {ReqAddr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
          state_d    = S_REQ0;
        end
      end
      S_REQ0: begin
        if (Flush)            state_d = S_IDLE;
        else if (MemReqReady) state_d = S_WAIT0;
      end
      S_WAIT0: begin
        if (Flush) begin
          // A response arriving with the flush settles the debt; otherwise wait for it.
          state_d = MemRespValid ? S_IDLE : S_DRAIN;
        end else if (MemRespValid) begin
          if (split_q) begin
            beat0_d    = MemRespData;
            mem_addr_d = mem_addr_q + ADDR_WIDTH'(B);
            state_d    = S_REQ1;
          end else begin
            load_data_d = align('0, MemRespData, off_q, size_q);
            state_d     = S_DONE;
          end
        end
      end
      S_REQ1: begin
        if (Flush)            state_d = S_IDLE;
        else if (MemReqReady) state_d = S_WAIT1;
      end
      S_WAIT1: begin
        if (Flush) begin
          state_d = MemRespValid ? S_IDLE : S_DRAIN;
        end else if (MemRespValid) begin
          load_data_d = align(MemRespData, beat0_q, off_q, size_q);
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (Flush || LoadReady) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (MemRespValid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      off_q       <= '0;
      size_q      <= '0;
      trunc_q     <= NO_TRUNC;
      rd_q        <= '0;
      split_q     <= 1'b0;
      beat0_q     <= '0;
      mem_addr_q  <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      trunc_q     <= trunc_d;
      rd_q        <= rd_d;
      split_q     <= split_d;
      beat0_q     <= beat0_d;
      mem_addr_q  <= mem_addr_d;
      load_data_q <= load_data_d;
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit with DATA_WIDTH=32.
// Inputs change and outputs are sampled on the falling edge.
// Each scenario task carries its own expected values.

module tb_load_align_unit;
  import load_align_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ReqValid;
  logic        ReqReady;
  logic [31:0] ReqAddr;
  logic [2:0]  ReqTruncSrc;
  logic [4:0]  ReqRd;
  logic        Flush;
  logic        MemReqValid;
  logic        MemReqReady;
  logic [31:0] MemAddr;
  logic        MemRespValid;
  logic [31:0] MemRespData;
  logic        LoadValid;
  logic        LoadReady;
  logic [31:0] LoadData;
  logic [2:0]  LoadTruncSrc;
  logic [4:0]  LoadRd;
  logic        LoadSplit;

  int total = 0;
  int bad   = 0;

  load_align_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddr(ReqAddr),
    .ReqTruncSrc(ReqTruncSrc), .ReqRd(ReqRd), .Flush(Flush),
    .MemReqValid(MemReqValid), .MemReqReady(MemReqReady), .MemAddr(MemAddr),
    .MemRespValid(MemRespValid), .MemRespData(MemRespData),
    .LoadValid(LoadValid), .LoadReady(LoadReady), .LoadData(LoadData),
    .LoadTruncSrc(LoadTruncSrc), .LoadRd(LoadRd), .LoadSplit(LoadSplit)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  // Present a request for one cycle; returns at the first cycle after acceptance.
  task automatic issue(input logic [31:0] a, input logic [2:0] t, input logic [4:0] r);
    ReqValid = 1'b1; ReqAddr = a; ReqTruncSrc = t; ReqRd = r;
    cyc();
    ReqValid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    MemRespValid = 1'b1; MemRespData = d;
    cyc();
    MemRespValid = 1'b0; MemRespData = 32'h0;
  endtask

  task automatic test_reset();
    total++; if (ReqReady !== 1'b1)        begin bad++; $display("FAIL rst_reqready got=%b exp=1", ReqReady); end
    total++; if (MemReqValid !== 1'b0)     begin bad++; $display("FAIL rst_memreqvalid got=%b exp=0", MemReqValid); end
    total++; if (LoadValid !== 1'b0)       begin bad++; $display("FAIL rst_loadvalid got=%b exp=0", LoadValid); end
    total++; if (LoadSplit !== 1'b0)       begin bad++; $display("FAIL rst_loadsplit got=%b exp=0", LoadSplit); end
    total++; if (MemAddr !== 32'h0)        begin bad++; $display("FAIL rst_memaddr got=%h exp=0", MemAddr); end
    total++; if (LoadData !== 32'h0)       begin bad++; $display("FAIL rst_loaddata got=%h exp=0", LoadData); end
    total++; if (LoadRd !== 5'd0)          begin bad++; $display("FAIL rst_loadrd got=%0d exp=0", LoadRd); end
    total++; if (LoadTruncSrc !== NO_TRUNC) begin bad++; $display("FAIL rst_trunc got=%0d exp=%0d", LoadTruncSrc, NO_TRUNC); end
  endtask

  task automatic test_aligned_word();
    issue(32'h0000_0100, WORD, 5'd5);                       // T+1: REQ0
    total++; if (MemReqValid !== 1'b1)    begin bad++; $display("FAIL word_memreqvalid got=%b exp=1", MemReqValid); end
    total++; if (MemAddr !== 32'h100)     begin bad++; $display("FAIL word_memaddr got=%h exp=00000100", MemAddr); end
    total++; if (ReqReady !== 1'b0)       begin bad++; $display("FAIL word_reqready_busy got=%b exp=0", ReqReady); end
    MemReqReady = 1'b1; cyc(); MemReqReady = 1'b0;          // T+2: WAIT0
    total++; if (MemReqValid !== 1'b0 || LoadValid !== 1'b0) begin bad++; $display("FAIL word_wait0 memreqvalid=%b loadvalid=%b exp=0/0", MemReqValid, LoadValid); end
    respond(32'hDEAD_BEEF);                                 // T+3: DONE
    total++; if (LoadValid !== 1'b1)      begin bad++; $display("FAIL word_loadvalid got=%b exp=1", LoadValid); end
    total++; if (LoadData !== 32'hDEADBEEF) begin bad++; $display("FAIL word_loaddata got=%h exp=deadbeef", LoadData); end
    total++; if (LoadSplit !== 1'b0)      begin bad++; $display("FAIL word_split got=%b exp=0", LoadSplit); end
    total++; if (LoadRd !== 5'd5)         begin bad++; $display("FAIL word_rd got=%0d exp=5", LoadRd); end
    total++; if (LoadTruncSrc !== WORD)   begin bad++; $display("FAIL word_trunc got=%0d exp=%0d", LoadTruncSrc, WORD); end
    LoadReady = 1'b1; cyc(); LoadReady = 1'b0;
    total++; if (LoadValid !== 1'b0 || ReqReady !== 1'b1) begin bad++; $display("FAIL word_release loadvalid=%b reqready=%b exp=0/1", LoadValid, ReqReady); end
  endtask

  task automatic test_byte_unsigned();
    issue(32'h0000_0103, BYTE_UNSIGNED, 5'd7);
    total++; if (MemAddr !== 32'h100)     begin bad++; $display("FAIL byte_memaddr got=%h exp=00000100", MemAddr); end
    MemReqReady = 1'b1; cyc(); MemReqReady = 1'b0;
    respond(32'h80FF_EE11);
    total++; if (LoadValid !== 1'b1)      begin bad++; $display("FAIL byte_loadvalid got=%b exp=1", LoadValid); end
    total++; if (LoadData !== 32'h0000_0080) begin bad++; $display("FAIL byte_loaddata got=%h exp=00000080", LoadData); end
    total++; if (LoadSplit !== 1'b0)      begin bad++; $display("FAIL byte_split got=%b exp=0", LoadSplit); end
    LoadReady = 1'b1; cyc(); LoadReady = 1'b0;
  endtask

  task automatic test_split_half();
    issue(32'h0000_0103, HALF_WORD, 5'd3);                  // T+1: REQ0
    total++; if (MemAddr !== 32'h100)     begin bad++; $display("FAIL half_memaddr0 got=%h exp=00000100", MemAddr); end
    MemReqReady = 1'b1; cyc(); MemReqReady = 1'b0;          // T+2: WAIT0
    respond(32'hAABB_CCDD);                                 // T+3: REQ1
    total++; if (MemReqValid !== 1'b1)    begin bad++; $display("FAIL half_memreqvalid1 got=%b exp=1", MemReqValid); end
    total++; if (MemAddr !== 32'h104)     begin bad++; $display("FAIL half_memaddr1 got=%h exp=00000104", MemAddr); end
    total++; if (LoadValid !== 1'b0)      begin bad++; $display("FAIL half_early_valid got=%b exp=0", LoadValid); end
    MemReqReady = 1'b1; cyc(); MemReqReady = 1'b0;          // T+4: WAIT1
    total++; if (LoadValid !== 1'b0)      begin bad++; $display("FAIL half_wait1_valid got=%b exp=0", LoadValid); end
    respond(32'h1122_3344);                                 // T+5: DONE
    total++; if (LoadValid !== 1'b1)      begin bad++; $display("FAIL half_loadvalid got=%b exp=1", LoadValid); end
    total++; if (LoadData !== 32'h0000_44AA) begin bad++; $display("FAIL half_loaddata got=%h exp=000044aa", LoadData); end
    total++; if (LoadSplit !== 1'b1)      begin bad++; $display("FAIL half_split got=%b exp=1", LoadSplit); end
    LoadReady = 1'b1; cyc(); LoadReady = 1'b0;
  endtask

  task automatic test_wrap();
    issue(32'hFFFF_FFFE, WORD, 5'd1);
    total++; if (MemAddr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_memaddr0 got=%h exp=fffffffc", MemAddr); end
    MemReqReady = 1'b1; cyc(); MemReqReady = 1'b0;
    respond(32'h3322_1100);
    total++; if (MemAddr !== 32'h0000_0000) begin bad++; $display("FAIL wrap_memaddr1 got=%h exp=00000000", MemAddr); end
    MemReqReady = 1'b1; cyc(); MemReqReady = 1'b0;
    respond(32'h7766_5544);
    total++; if (LoadData !== 32'h5544_3322) begin bad++; $display("FAIL wrap_loaddata got=%h exp=55443322", LoadData); end
    total++; if (LoadSplit !== 1'b1)      begin bad++; $display("FAIL wrap_split got=%b exp=1", LoadSplit); end
    LoadReady = 1'b1; cyc(); LoadReady = 1'b0;
  endtask

  task automatic test_flush_wait0();
    issue(32'h0000_0200, BYTE, 5'd2);
    MemReqReady = 1'b1; cyc(); MemReqReady = 1'b0;          // WAIT0
    Flush = 1'b1; cyc(); Flush = 1'b0;                      // DRAIN
    total++; if (ReqReady !== 1'b0)       begin bad++; $display("FAIL flush_drain_reqready got=%b exp=0", ReqReady); end
    cyc();
    total++; if (ReqReady !== 1'b0 || LoadValid !== 1'b0) begin bad++; $display("FAIL flush_drain_hold reqready=%b loadvalid=%b exp=0/0", ReqReady, LoadValid); end
    respond(32'h1234_5678);                                 // owed response absorbed
    total++; if (ReqReady !== 1'b1)       begin bad++; $display("FAIL flush_idle_reqready got=%b exp=1", ReqReady); end
    total++; if (LoadValid !== 1'b0)      begin bad++; $display("FAIL flush_no_result got=%b exp=0", LoadValid); end
    issue(32'h0000_0300, WORD, 5'd4);
    total++; if (MemAddr !== 32'h300)     begin bad++; $display("FAIL flush_next_memaddr got=%h exp=00000300", MemAddr); end
    MemReqReady = 1'b1; cyc(); MemReqReady = 1'b0;
    respond(32'hCAFE_F00D);
    total++; if (LoadValid !== 1'b1 || LoadData !== 32'hCAFEF00D) begin bad++; $display("FAIL flush_next_data valid=%b data=%h exp=1/cafef00d", LoadValid, LoadData); end
    LoadReady = 1'b1; cyc(); LoadReady = 1'b0;
  endtask

  task automatic test_stall();
    issue(32'h0000_0104, WORD, 5'd9);
    for (int i = 0; i < 3; i++) begin
      MemRespValid = 1'b1; MemRespData = 32'hFFFF_FFFF;     // stray response must be ignored in REQ0
      total++; if (MemReqValid !== 1'b1 || MemAddr !== 32'h104) begin bad++; $display("FAIL stall_req%0d valid=%b addr=%h exp=1/00000104", i, MemReqValid, MemAddr); end
      cyc();
    end
    MemRespValid = 1'b0;
    total++; if (MemReqValid !== 1'b1 || MemAddr !== 32'h104) begin bad++; $display("FAIL stall_req_last valid=%b addr=%h exp=1/00000104", MemReqValid, MemAddr); end
    MemReqReady = 1'b1; cyc(); MemReqReady = 1'b0;
    respond(32'h0BAD_F00D);
    for (int i = 0; i < 4; i++) begin
      total++; if (LoadValid !== 1'b1 || LoadData !== 32'h0BADF00D || LoadRd !== 5'd9 || LoadTruncSrc !== WORD)
        begin bad++; $display("FAIL stall_done%0d valid=%b data=%h rd=%0d trunc=%0d exp=1/0badf00d/9/%0d", i, LoadValid, LoadData, LoadRd, LoadTruncSrc, WORD); end
      cyc();
    end
    LoadReady = 1'b1; cyc(); LoadReady = 1'b0;
    total++; if (ReqReady !== 1'b1)       begin bad++; $display("FAIL stall_release got=%b exp=1", ReqReady); end
  endtask

  task automatic test_reset_wait1();
    issue(32'h0000_0103, HALF_WORD_UNSIGNED, 5'd12);
    MemReqReady = 1'b1; cyc(); MemReqReady = 1'b0;
    respond(32'hAABB_CCDD);
    MemReqReady = 1'b1; cyc(); MemReqReady = 1'b0;          // WAIT1
    reset_n = 1'b0; cyc();
    total++; if (ReqReady !== 1'b1 || MemReqValid !== 1'b0 || LoadValid !== 1'b0 || LoadSplit !== 1'b0)
      begin bad++; $display("FAIL midrst_ctrl reqready=%b memreqvalid=%b loadvalid=%b split=%b exp=1/0/0/0", ReqReady, MemReqValid, LoadValid, LoadSplit); end
    total++; if (MemAddr !== 32'h0 || LoadData !== 32'h0 || LoadRd !== 5'd0 || LoadTruncSrc !== NO_TRUNC)
      begin bad++; $display("FAIL midrst_data addr=%h data=%h rd=%0d trunc=%0d exp=0/0/0/%0d", MemAddr, LoadData, LoadRd, LoadTruncSrc, NO_TRUNC); end
    reset_n = 1'b1; cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; ReqValid = 1'b0; ReqAddr = '0; ReqTruncSrc = NO_TRUNC; ReqRd = '0;
    Flush = 1'b0; MemReqReady = 1'b0; MemRespValid = 1'b0; MemRespData = '0; LoadReady = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    test_reset();
    test_aligned_word();
    test_byte_unsigned();
    test_split_half();
    test_wrap();
    test_flush_wait0();
    test_stall();
    test_reset_wait1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
